// File: rtl/batcharger_pkg.sv
// rtl/batcharger_pkg.sv - shared state encoding and ADC scale constants for the charger controller
package batcharger_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_TC    = 3'd1,
    ST_CC    = 3'd2,
    ST_CV    = 3'd3,
    ST_DONE  = 3'd4,
    ST_FAULT = 3'd5
  } state_e;

  // ADC scaling: voltage codes are 51 LSB per volt, current full scale (1C) is 255
  localparam int VLSB_PER_V = 51;
  localparam int IBAT_FS    = 255;

  function automatic logic is_charging(state_e s);
    return (s == ST_TC) || (s == ST_CC) || (s == ST_CV);
  endfunction

endpackage

// File: rtl/batcharger_ctrl_fsm_if.sv
// rtl/batcharger_ctrl_fsm_if.sv - monitor-side inputs and power-block enables of the charge sequencer
interface batcharger_ctrl_fsm_if #(
  parameter int CNT_W = 16
);
  logic             en;
  logic             vtok;
  logic [7:0]       vbat;
  logic [7:0]       ibat;
  logic [7:0]       tbat;
  logic [7:0]       vcutoff;
  logic [7:0]       vpreset;
  logic [7:0]       iend;
  logic [7:0]       tempmin;
  logic [7:0]       tempmax;
  logic [CNT_W-1:0] tmax;
  logic             tc;
  logic             cc;
  logic             cv;
  logic             vmonen;
  logic             tmonen;
  logic             imonen;
  logic             done;
  logic             fault;
  logic [2:0]       state;

  modport master (
    output en, vtok, vbat, ibat, tbat, vcutoff, vpreset, iend, tempmin, tempmax, tmax,
    input  tc, cc, cv, vmonen, tmonen, imonen, done, fault, state
  );

  modport slave (
    input  en, vtok, vbat, ibat, tbat, vcutoff, vpreset, iend, tempmin, tempmax, tmax,
    output tc, cc, cv, vmonen, tmonen, imonen, done, fault, state
  );
endinterface

// File: rtl/batcharger_phase_timer.sv
// rtl/batcharger_phase_timer.sv - saturating per-phase cycle counter with zero-disabled timeout compare
module batcharger_phase_timer #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rstz,
  input  logic             clear,
  input  logic             inc,
  input  logic [CNT_W-1:0] tmax,
  output logic             expired
);

  logic [CNT_W-1:0] count_q;

  always_ff @(posedge clk or negedge rstz) begin
    if (!rstz) begin
      count_q <= '0;
    end else if (clear) begin
      count_q <= '0;
    end else if (inc && (count_q != '1)) begin
      count_q <= count_q + CNT_W'(1);
    end
  end

  // Firing on equality gives a phase length of tmax+1 cycles
  assign expired = (tmax != '0) && (count_q == tmax);

endmodule

// File: rtl/batcharger_ctrl_fsm.sv
// rtl/batcharger_ctrl_fsm.sv - charge sequencer selecting trickle, CC or CV mode with safety timeout
module batcharger_ctrl_fsm
  import batcharger_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic                   clk,
  input  logic                   rstz,
  batcharger_ctrl_fsm_if.slave   bus
);

  state_e state_q, state_d;
  logic   tc_q, cc_q, cv_q, vmonen_q, tmonen_q, imonen_q, done_q, fault_q;
  logic   tok;
  logic   expired;

  assign tok = (bus.tbat >= bus.tempmin) && (bus.tbat <= bus.tempmax);

  batcharger_phase_timer #(.CNT_W(CNT_W)) u_timer (
    .clk     (clk),
    .rstz    (rstz),
    .clear   (state_d != state_q),
    .inc     (is_charging(state_q)),
    .tmax    (bus.tmax),
    .expired (expired)
  );

  always_comb begin
    state_d = state_q;
    if (!bus.en || !bus.vtok) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (tok) begin
            if (bus.vbat < bus.vcutoff)      state_d = ST_TC;
            else if (bus.vbat < bus.vpreset) state_d = ST_CC;
            else                             state_d = ST_CV;
          end
        end
        ST_TC: begin
          if (!tok)                          state_d = ST_FAULT;
          else if (expired)                  state_d = ST_FAULT;
          else if (bus.vbat >= bus.vcutoff)  state_d = ST_CC;
        end
        ST_CC: begin
          if (!tok)                          state_d = ST_FAULT;
          else if (expired)                  state_d = ST_DONE;
          else if (bus.vbat >= bus.vpreset)  state_d = ST_CV;
        end
        ST_CV: begin
          if (!tok)                          state_d = ST_FAULT;
          else if (expired)                  state_d = ST_DONE;
          else if (bus.ibat <= bus.iend)     state_d = ST_DONE;
        end
        ST_DONE:  state_d = ST_DONE;
        ST_FAULT: state_d = ST_FAULT;
        default:  state_d = ST_IDLE;
      endcase
    end
  end

  // Outputs decode the next state so enables switch on the same edge as the state
  always_ff @(posedge clk or negedge rstz) begin
    if (!rstz) begin
      state_q  <= ST_IDLE;
      tc_q     <= 1'b0;
      cc_q     <= 1'b0;
      cv_q     <= 1'b0;
      vmonen_q <= 1'b0;
      tmonen_q <= 1'b0;
      imonen_q <= 1'b0;
      done_q   <= 1'b0;
      fault_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      tc_q     <= (state_d == ST_TC);
      cc_q     <= (state_d == ST_CC);
      cv_q     <= (state_d == ST_CV);
      vmonen_q <= is_charging(state_d);
      tmonen_q <= is_charging(state_d);
      imonen_q <= (state_d == ST_CV);
      done_q   <= (state_d == ST_DONE);
      fault_q  <= (state_d == ST_FAULT);
    end
  end

  assign bus.tc     = tc_q;
  assign bus.cc     = cc_q;
  assign bus.cv     = cv_q;
  assign bus.vmonen = vmonen_q;
  assign bus.tmonen = tmonen_q;
  assign bus.imonen = imonen_q;
  assign bus.done   = done_q;
  assign bus.fault  = fault_q;
  assign bus.state  = state_q;

endmodule

// File: doc/batcharger_ctrl_fsm.md
# batcharger_ctrl_fsm

- Digital charge-sequencing controller for the 64-bit real-valued battery charger power block.
- Drives that block's mode enables `cc`, `tc` and `cv`, choosing trickle, constant-current or constant-voltage charging from digitised battery voltage, current and temperature, with a per-phase safety timeout.
- Sits between the monitor ADCs and the power block; `icc`, `itc`, `vcv` and `sel` reach the power block directly from the configuration registers, not through this block.

## Interface

Parameters:
- CNT_W, 16, width of the phase timer and of `tmax`

Ports:
- clk  in  1  controller clock
- rstz  in  1  asynchronous, active-low reset
- en  in  1  charger enable (level)
- vtok  in  1  input supply valid (vin at least 200 mV above battery)
- vbat  in  8  battery voltage code, 51 LSB/V (255 = 5 V)
- ibat  in  8  battery current code, 255 = 1C
- tbat  in  8  battery temperature code
- vcutoff  in  8  trickle/CC boundary voltage code
- vpreset  in  8  CC/CV boundary voltage code (equal to `vcv` target)
- iend  in  8  end-of-charge current code in CV
- tempmin  in  8  lowest allowed temperature code
- tempmax  in  8  highest allowed temperature code
- tmax  in  CNT_W  per-phase timeout in cycles; 0 disables the timeout
- tc  out  1  trickle mode enable to the power block
- cc  out  1  constant-current mode enable
- cv  out  1  constant-voltage mode enable
- vmonen  out  1  voltage monitor enable
- tmonen  out  1  temperature monitor enable
- imonen  out  1  current monitor enable
- done  out  1  charge complete
- fault  out  1  charge aborted
- state  out  3  current state code

## Operation

States and codes: IDLE=0, TC=1, CC=2, CV=3, DONE=4, FAULT=5. Codes 6 and 7 are illegal and go to IDLE.

- Temperature ok (`tok`) means `tempmin <= tbat <= tempmax`, unsigned compare.
- Priority when several conditions hold in the same cycle: `en`/`vtok` loss, then temperature, then timeout, then threshold.
  1. `en`=0 or `vtok`=0: go to IDLE from any state.
  2. In TC, CC or CV, `!tok`: go to FAULT.
  3. Timeout: TC goes to FAULT (dead cell). CC and CV go to DONE.
  4. Threshold transitions are listed below.
- IDLE, when `en & vtok & tok`:
  - `vbat < vcutoff`: go to TC.
  - else `vbat < vpreset`: go to CC.
  - else: go to CV.
  - If `tok` is false, stay in IDLE.
- TC: `vbat >= vcutoff` goes to CC.
- CC: `vbat >= vpreset` goes to CV.
- CV: `ibat <= iend` goes to DONE.
- DONE and FAULT are latched. They leave only through rule 1.

Phase timer:
- Clears to 0 on every state change.
- Increments by 1 each cycle in TC, CC and CV; holds in all other states; saturates at all-ones.
- Timeout fires when `tmax != 0` and `timer == tmax`, so the phase lasts `tmax+1` cycles.

Outputs are registered and decoded from the next state:
- `tc`, `cc`, `cv` are one-hot when in TC, CC or CV respectively; all zero otherwise.
- `vmonen` and `tmonen` are 1 in TC, CC and CV.
- `imonen` is 1 in CV only.
- `done` is 1 in DONE; `fault` is 1 in FAULT.

## Timing

- Reset (`rstz`=0, asynchronous): state=IDLE, timer=0, every output 0.
- Latency: inputs sampled on a rising `clk` edge are reflected in `state` and all outputs at that same edge's register update, i.e. one cycle of latency.
- Mode handover on CC→CV or TC→CC happens in a single edge: the old enable falls and the new one rises together. There is never a zero-enable gap and never two enables high at once.
- `en` deasserted for one cycle is enough to clear DONE or FAULT. Re-entry from IDLE takes one more cycle.
- Reset asserted mid-phase clears all outputs immediately, without waiting for a clock edge.
- Threshold inputs are level-sampled. Glitch filtering is the ADC's responsibility, not this block's.

## Structure

- Shared package `batcharger_pkg` holds:
  - the state enum and its 3-bit encoding;
  - the ADC scale constants: `VLSB_PER_V=51` and the current full-scale code 255.
- Sub-module `batcharger_phase_timer` holds the CNT_W saturating counter with `clear` and `inc` inputs and the `tmax`/zero-disable compare, producing `expired`.
- The FSM plus output decode stays in `batcharger_ctrl_fsm`.

## Test plan

Common setup for all scenarios: `vcutoff=153` (3.0 V), `vpreset=188` (3.7 V), `iend=25`, `tempmin=40`, `tempmax=200`, `tbat=100`, `tmax=0` unless stated.

1. Full charge cycle:
   - Stimulus: `vbat=140`, `en=vtok=1`, then ramp `vbat` to 153, then 188, then drop `ibat` from 127 to 25.
   - Required: states IDLE→TC→CC→CV→DONE; `tc`, `cc`, `cv` one-hot with no gap; `done`=1.
2. Timeouts:
   - CC case: `tmax=10`, `vbat=170` held. Required: `cc` high for exactly 11 cycles, then DONE.
   - TC case: same, with `vbat=140`. Required: FAULT after 11 cycles.
3. Temperature:
   - Stimulus: `tbat=210` during CC.
   - Required: FAULT next cycle, `cc`=0, `fault`=1; state stays FAULT after `tbat` returns to 100. Release `en` → IDLE.
4. Supply loss mid-CV:
   - Stimulus: `vtok`=0 for one cycle.
   - Required: IDLE with all outputs 0; after `vtok`=1 and `vbat=190`, CV is re-entered.
5. Simultaneous events:
   - CC case: `vbat` reaches 188 in the same cycle as timeout. Required: DONE, not CV.
   - IDLE case: `vbat=200` at start. Required: direct IDLE→CV.
6. Asynchronous reset:
   - Stimulus: `rstz` pulsed low between clock edges during CV.
   - Required: `cv`, `imonen` and `state` go to 0 before the next edge.
